// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM symbol feeder.
// Contents: FFT size limits, a log2(N) clamp helper, the write/read FSM
// state encodings and the ping-pong bank index type.
package ofdm_pkg;

    // Width of the runtime log2(N) configuration field
    localparam int unsigned LOG2N_W       = 4;
    // Default FFT size limits (log2); the top-level parameters override these
    localparam int unsigned LOG2N_MIN_DEF = 2;
    localparam int unsigned LOG2N_MAX_DEF = 8;

    typedef enum logic [1:0] {
        W_CP   = 2'd0,
        W_DATA = 2'd1,
        W_DROP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rd_state_e;

    // Selects one of the two ping-pong banks
    typedef logic bank_t;

    // Clamp a requested log2(N) into [lo, hi]
    function automatic logic [LOG2N_W-1:0] clamp_log2n(
        input logic [LOG2N_W-1:0] req,
        input logic [LOG2N_W-1:0] lo,
        input logic [LOG2N_W-1:0] hi
    );
        if (req < lo) return lo;
        if (req > hi) return hi;
        return req;
    endfunction

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// Two-bank simple dual-port RAM used as the symbol ping-pong buffer.
// Ports:
//   clk, rst_ni         clock and synchronous active-low reset (read register only)
//   wr_en_i/bank/addr   write port, data written on the clock edge
//   rd_en_i/bank/addr   read port; rd_data_o is registered and holds when rd_en_i==0
// The bank index forms the MSB of the physical address.
module ofdm_pingpong_ram
    import ofdm_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  bank_t             wr_bank_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  bank_t             rd_bank_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array, no reset
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
    end

    // Registered read port; output holds between reads
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofdm_symbol_feeder.sv
// OFDM receive front-end: strips the cyclic prefix, assembles N-point symbols
// in a ping-pong buffer and streams each one as a gap-free burst to the FFT.
// Ports:
//   clk, reset                   clock, synchronous active-low reset
//   cfg_load/cfg_log2n/cfg_cp_len  runtime N and CP, accepted only when idle
//   valid, data_in_i/q           input sample stream
//   flag_wayt_data               FFT ready for a full symbol
//   valid_out, data_out_i/q      output burst, sym_first marks beat 0
//   overflow, drop_count         sticky overflow and saturating drop counter
//   busy                         any bank holds or is receiving data
module ofdm_symbol_feeder
    import ofdm_pkg::*;
#(
    parameter int unsigned SIZE_BUFFER   = LOG2N_MAX_DEF,
    parameter int unsigned MIN_LOG2N     = LOG2N_MIN_DEF,
    parameter int unsigned DATA_FFT_SIZE = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_load,
    input  logic [LOG2N_W-1:0]       cfg_log2n,
    input  logic [SIZE_BUFFER-1:0]   cfg_cp_len,
    input  logic                     valid,
    input  logic [DATA_FFT_SIZE-1:0] data_in_i,
    input  logic [DATA_FFT_SIZE-1:0] data_in_q,
    input  logic                     flag_wayt_data,
    output logic                     valid_out,
    output logic [DATA_FFT_SIZE-1:0] data_out_i,
    output logic [DATA_FFT_SIZE-1:0] data_out_q,
    output logic                     sym_first,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     busy
);

    localparam int unsigned IDX_W  = SIZE_BUFFER;
    localparam int unsigned WORD_W = 2 * DATA_FFT_SIZE;

    logic [LOG2N_W-1:0] log2n_q;
    logic [IDX_W-1:0]   cp_len_q, cp_cnt_q, wcnt_q, rcnt_q;
    wr_state_e          wstate_q;
    rd_state_e          rstate_q;
    bank_t              wb_q, rb_q;
    logic [1:0]         full_q;
    logic               overflow_q, valid_out_q, sym_first_q;
    logic [CNT_W-1:0]   drop_cnt_q;

    logic [IDX_W-1:0]   n_last_c, wr_addr_c, rd_addr_c, cfg_nlast_c, cfg_cp_c;
    logic [LOG2N_W-1:0] cfg_l2_c;
    logic [1:0]         set_mask_c, clr_mask_c;
    logic               wr_en_c, rd_en_c, busy_c, cfg_accept_c;
    logic [WORD_W-1:0]  rd_data_c;

    // Index of the last sample in a symbol (N-1)
    assign n_last_c = IDX_W'((32'd1 << log2n_q) - 32'd1);

    assign busy_c = (|full_q) | (wstate_q != W_CP) | (cp_cnt_q != '0)
                  | (rstate_q != R_IDLE) | valid_out_q;
    assign cfg_accept_c = cfg_load & ~busy_c;

    // Clamp the requested config: N into range, CP to at most N-1
    assign cfg_l2_c    = clamp_log2n(cfg_log2n, LOG2N_W'(MIN_LOG2N), LOG2N_W'(SIZE_BUFFER));
    assign cfg_nlast_c = IDX_W'((32'd1 << cfg_l2_c) - 32'd1);
    assign cfg_cp_c    = (cfg_cp_len > cfg_nlast_c) ? cfg_nlast_c : cfg_cp_len;

    // Write-port decode; the sample that completes the CP is data sample 0
    always_comb begin
        wr_en_c    = 1'b0;
        wr_addr_c  = '0;
        set_mask_c = '0;
        if (valid) begin
            if (wstate_q == W_CP && cp_cnt_q == cp_len_q && !full_q[wb_q]) begin
                wr_en_c = 1'b1;
            end else if (wstate_q == W_DATA) begin
                wr_en_c   = 1'b1;
                wr_addr_c = wcnt_q;
                if (wcnt_q == n_last_c) set_mask_c[wb_q] = 1'b1;
            end
        end
    end

    // Write FSM: CP strip, symbol capture, overflow drop
    always_ff @(posedge clk) begin
        if (!reset) begin
            wstate_q   <= W_CP;
            cp_cnt_q   <= '0;
            wcnt_q     <= '0;
            wb_q       <= 1'b0;
            log2n_q    <= LOG2N_W'(SIZE_BUFFER);
            cp_len_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (cfg_accept_c) begin
                log2n_q    <= cfg_l2_c;
                cp_len_q   <= cfg_cp_c;
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end
            if (valid) begin
                case (wstate_q)
                    W_CP: begin
                        if (cp_cnt_q == cp_len_q) begin
                            cp_cnt_q <= '0;
                            wcnt_q   <= IDX_W'(1);
                            if (full_q[wb_q]) begin
                                wstate_q   <= W_DROP;
                                overflow_q <= 1'b1;
                                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                            end else begin
                                wstate_q <= W_DATA;
                            end
                        end else begin
                            cp_cnt_q <= cp_cnt_q + IDX_W'(1);
                        end
                    end
                    W_DATA, W_DROP: begin
                        if (wcnt_q == n_last_c) begin
                            wcnt_q   <= '0;
                            wstate_q <= W_CP;
                            // A dropped symbol retries the same bank next time
                            if (wstate_q == W_DATA) wb_q <= ~wb_q;
                        end else begin
                            wcnt_q <= wcnt_q + IDX_W'(1);
                        end
                    end
                    default: wstate_q <= W_CP;
                endcase
            end
        end
    end

    // Read-port decode; address 0 is issued in the cycle the burst is granted
    always_comb begin
        rd_en_c    = 1'b0;
        rd_addr_c  = '0;
        clr_mask_c = '0;
        case (rstate_q)
            R_IDLE: begin
                if (full_q[rb_q] && flag_wayt_data) rd_en_c = 1'b1;
            end
            R_SEND: begin
                rd_en_c   = 1'b1;
                rd_addr_c = rcnt_q;
                if (rcnt_q == n_last_c) clr_mask_c[rb_q] = 1'b1;
            end
        endcase
    end

    // Read FSM; once started a burst runs to completion
    always_ff @(posedge clk) begin
        if (!reset) begin
            rstate_q    <= R_IDLE;
            rcnt_q      <= '0;
            rb_q        <= 1'b0;
            valid_out_q <= 1'b0;
            sym_first_q <= 1'b0;
        end else begin
            valid_out_q <= rd_en_c;
            sym_first_q <= rd_en_c && (rstate_q == R_IDLE);
            case (rstate_q)
                R_IDLE: begin
                    if (rd_en_c) begin
                        rstate_q <= R_SEND;
                        rcnt_q   <= IDX_W'(1);
                    end
                end
                R_SEND: begin
                    if (rcnt_q == n_last_c) begin
                        rstate_q <= R_IDLE;
                        rcnt_q   <= '0;
                        rb_q     <= ~rb_q;
                    end else begin
                        rcnt_q <= rcnt_q + IDX_W'(1);
                    end
                end
            endcase
        end
    end

    // Bank full flags; set and clear always target different banks
    always_ff @(posedge clk) begin
        if (!reset) full_q <= '0;
        else        full_q <= (full_q | set_mask_c) & ~clr_mask_c;
    end

    ofdm_pingpong_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk       (clk),
        .rst_ni    (reset),
        .wr_en_i   (wr_en_c),
        .wr_bank_i (wb_q),
        .wr_addr_i (wr_addr_c),
        .wr_data_i ({data_in_i, data_in_q}),
        .rd_en_i   (rd_en_c),
        .rd_bank_i (rb_q),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (rd_data_c)
    );

    assign valid_out  = valid_out_q;
    assign sym_first  = sym_first_q;
    assign data_out_i = rd_data_c[WORD_W-1:DATA_FFT_SIZE];
    assign data_out_q = rd_data_c[DATA_FFT_SIZE-1:0];
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;
    assign busy       = busy_c;

endmodule

// File: tb/tb_ofdm_symbol_feeder.sv
// Scoreboard bench for ofdm_symbol_feeder: a frame-level model turns the
// sample stream into expected output beats; a monitor checks every beat.
module tb_ofdm_symbol_feeder;

    localparam int unsigned SB = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset, cfg_load, valid, flag_wayt_data;
    logic [3:0]    cfg_log2n;
    logic [SB-1:0] cfg_cp_len;
    logic [DW-1:0] data_in_i, data_in_q, data_out_i, data_out_q;
    logic          valid_out, sym_first, overflow, busy;
    logic [CW-1:0] drop_count;

    always #5 clk = ~clk;

    ofdm_symbol_feeder #(
        .SIZE_BUFFER(SB), .MIN_LOG2N(2), .DATA_FFT_SIZE(DW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_log2n(cfg_log2n),
        .cfg_cp_len(cfg_cp_len), .valid(valid), .data_in_i(data_in_i),
        .data_in_q(data_in_q), .flag_wayt_data(flag_wayt_data),
        .valid_out(valid_out), .data_out_i(data_out_i), .data_out_q(data_out_q),
        .sym_first(sym_first), .overflow(overflow), .drop_count(drop_count),
        .busy(busy)
    );

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        bit          first;
        bit          last;
        bit          cont;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    beats    = 0;
    int    cyc      = 0;
    int    last_beat_cyc = 0;
    bit    mon_en   = 1'b0;
    bit    in_burst = 1'b0;

    // Frame-level reference model state
    int m_n, m_cp, m_pos, m_drops, held;
    int m_buf[$];
    bit m_drop_cur, rd_blocked;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_n = 256; m_cp = 0; m_pos = 0; m_drops = 0; held = 0;
        m_drop_cur = 1'b0; rd_blocked = 1'b0;
        m_buf.delete();
    endtask

    task automatic model_cfg(input int l2req, input int cpreq);
        int l2;
        l2 = l2req;
        if (l2 < 2) l2 = 2;
        if (l2 > 8) l2 = 8;
        m_n  = 1 << l2;
        m_cp = (cpreq > m_n - 1) ? m_n - 1 : cpreq;
        m_drops = 0;
    endtask

    task automatic push_symbol();
        beat_t b;
        bit    cont;
        cont = rd_blocked && (held == 1);
        for (int k = 0; k < m_n; k++) begin
            b.i     = 16'(m_buf[k]);
            b.q     = 16'(m_buf[k]) ^ 16'h5A5A;
            b.first = (k == 0);
            b.last  = (k == m_n - 1);
            b.cont  = cont && (k == 0);
            sb.push_back(b);
        end
        m_buf.delete();
        if (rd_blocked) held++;
    endtask

    // A frame is CP discarded samples followed by N data samples
    task automatic model_sample(input int v);
        if (m_pos == m_cp) begin
            m_drop_cur = rd_blocked && (held >= 2);
            if (m_drop_cur) m_drops++;
        end
        if (m_pos >= m_cp && !m_drop_cur) m_buf.push_back(v);
        m_pos++;
        if (m_pos == m_cp + m_n) begin
            if (!m_drop_cur) push_symbol();
            m_pos = 0;
            m_drop_cur = 1'b0;
        end
    endtask

    task automatic drive_sample(input int v);
        valid     = 1'b1;
        data_in_i = 16'(v);
        data_in_q = 16'(v) ^ 16'h5A5A;
        model_sample(v);
        tick();
        valid = 1'b0;
    endtask

    // mode 0: contiguous, 1: idle cycle after every sample, 2: random idles
    task automatic feed(input int first_v, input int count, input int mode);
        for (int k = 0; k < count; k++) begin
            drive_sample(first_v + k);
            if (mode == 1) tick();
            else if (mode == 2 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic cfg(input int l2, input int cp, input bit apply);
        cfg_load   = 1'b1;
        cfg_log2n  = 4'(l2);
        cfg_cp_len = 8'(cp);
        tick();
        cfg_load = 1'b0;
        if (apply) model_cfg(l2, cp);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        sb.delete();
        tick();
        tick();
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k;
        k = 0;
        while (beats < target && k < budget) begin
            tick();
            k++;
        end
        chk("beats_reached", 64'(beats >= target), 64'd1);
    endtask

    // Monitor: pops the scoreboard on every output beat
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!mon_en || !reset) begin
            in_burst = 1'b0;
        end else if (valid_out) begin
            beats++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(valid_out), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("beat", {31'd0, sym_first, data_out_i, data_out_q},
                            {31'd0, e.first, e.i, e.q});
                if (e.cont) chk("b2b_gap", 64'(cyc - last_beat_cyc), 64'd1);
                in_burst      = !e.last;
                last_beat_cyc = cyc;
            end
        end else if (in_burst) begin
            chk("burst_gap", 64'(valid_out), 64'd1);
            in_burst = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, l2r, cpr, nfr;
        bit seen;

        reset = 1'b0; cfg_load = 1'b0; valid = 1'b0; flag_wayt_data = 1'b0;
        cfg_log2n = '0; cfg_cp_len = '0; data_in_i = '0; data_in_q = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_sym_first", 64'(sym_first), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'({data_out_i, data_out_q}), 64'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        tick();

        // Default config after reset: N=256, CP=0
        flag_wayt_data = 1'b1;
        feed(1000, 256, 0);
        drain(400);

        // Basic strip with latency check
        cfg(8, 16, 1'b1);
        feed(0, 272, 0);
        chk("lat_pre", 64'(valid_out), 64'd0);
        tick();
        chk("lat_first", 64'({valid_out, sym_first, data_out_i}), 64'({1'b1, 1'b1, 16'd16}));
        drain(400);

        // Smallest FFT, zero CP, and clamping of a too-small log2n
        cfg(2, 0, 1'b1);
        feed(0, 4, 0);
        drain(20);
        cfg(1, 0, 1'b1);
        feed(0, 4, 0);
        drain(20);

        // Back-pressure: two symbols held, third dropped
        flag_wayt_data = 1'b0;
        cfg(6, 8, 1'b1);
        rd_blocked = 1'b1;
        held = 0;
        feed(0, 3 * 72, 0);
        repeat (3) tick();
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_drop_count", 64'(drop_count), 64'(m_drops));
        chk("ovf_busy", 64'(busy), 64'd1);
        flag_wayt_data = 1'b1;
        rd_blocked = 1'b0;
        held = 0;
        drain(400);
        chk("ovf_idle_busy", 64'(busy), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // cfg_load while idle clears the overflow status
        cfg(4, 4, 1'b1);
        chk("cfg_clr_overflow", 64'(overflow), 64'd0);
        chk("cfg_clr_drop", 64'(drop_count), 64'd0);

        // Gapped input still yields one gap-free burst
        feed(100, 20, 1);
        drain(100);

        // cfg_load while busy is ignored
        feed(200, 2, 0);
        chk("guard_busy", 64'(busy), 64'd1);
        cfg(2, 0, 1'b0);
        feed(202, 18, 0);
        drain(100);

        // flag_wayt_data falling mid-burst does not cut the burst
        b0 = beats;
        feed(300, 20, 0);
        wait_beats(b0 + 10, 100);
        flag_wayt_data = 1'b0;
        drain(100);
        flag_wayt_data = 1'b1;

        // Reset mid-burst discards everything
        b0 = beats;
        feed(400, 20, 0);
        wait_beats(b0 + 10, 100);
        mon_en = 1'b0;
        reset = 1'b0;
        tick();
        chk("midrst_valid_out", 64'(valid_out), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_data", 64'({data_out_i, data_out_q}), 64'd0);
        sb.delete();
        model_reset();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | valid_out;
        end
        chk("post_reset_quiet", 64'(seen), 64'd0);

        // Randomized configs and input gaps with the FFT always ready
        for (int it = 0; it < 6; it++) begin
            l2r = $urandom_range(0, 7);
            cpr = $urandom_range(0, 255);
            nfr = $urandom_range(1, 3);
            cfg(l2r, cpr, 1'b1);
            feed($urandom_range(0, 4000), nfr * (m_cp + m_n), 2);
            drain(3000);
        end
        chk("rand_drop_count", 64'(drop_count), 64'(m_drops));
        chk("rand_overflow", 64'(overflow), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
